// File: rtl/async_micropipeline_param.sv
`timescale 1ns/10ps
// async_micropipeline_param
// Bundled-data asynchronous micropipeline built from a chain of Muller C
// elements. DEPTH internal data stages feed one output stage. There is no clock.
// MODE 0 uses four-phase (return-to-zero) handshaking and MODE 1 uses
// two-phase (transition) handshaking.
//
// Ports:
//   reset       async active-low; clears the request chain and all data
//   req_in      producer request
//   data_in     producer data, bundled with req_in
//   ack_out     acknowledge to producer (output of the first C element)
//   req_out     request to consumer (output of the last C element)
//   data_out    output-stage data register
//   ack_in      consumer acknowledge
//   stage_req   request of internal stage k at bit k-1
//   stage_data  data of internal stage k at bits [k*WIDTH-1 -: WIDTH]
//   occupancy   number of internal stages whose request differs from the next one
module async_micropipeline_param #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter bit          MODE    = 1'b0,
    parameter int unsigned C_DELAY = 1
) (
    input  logic                        reset,
    input  logic                        req_in,
    input  logic [WIDTH-1:0]            data_in,
    output logic                        ack_out,
    output logic                        req_out,
    output logic [WIDTH-1:0]            data_out,
    input  logic                        ack_in,
    output logic [DEPTH-1:0]            stage_req,
    output logic [DEPTH*WIDTH-1:0]      stage_data,
    output logic [$clog2(DEPTH+2)-1:0]  occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 2);

    // Request chain: r[0] is req_in, r[1..DEPTH+1] are C outputs, r[DEPTH+2] is ack_in
    logic [DEPTH+2:0] r;
    // Data chain: sd[0] is data_in, sd[1..DEPTH] are the stages, sd[DEPTH+1] is data_out
    logic [WIDTH-1:0] sd [0:DEPTH+1];
    // One bit per internal stage that holds a token
    logic [DEPTH-1:0] tok;

    assign r[0]       = req_in;
    assign r[DEPTH+2] = ack_in;
    assign sd[0]      = data_in;

    for (genvar k = 1; k <= DEPTH + 1; k++) begin : g_stage
        logic             set_c;
        logic             clr_c;
        logic             set_d;
        logic             clr_d;
        logic             c_q;
        logic [WIDTH-1:0] d_q;

        // The C inputs are r[k-1] and ~r[k+1]. Set when both inputs are 1, clear when both are 0.
        // Both terms are gated by reset, so no edge can be pending when reset is released.
        assign set_c = reset &  r[k-1] & ~r[k+1];
        assign clr_c = reset & ~r[k-1] &  r[k+1];

        // C-element propagation delay
        assign #(C_DELAY) set_d = set_c;
        assign #(C_DELAY) clr_d = clr_c;

        // C-element state. set_d and clr_d are mutually exclusive.
        always_ff @(posedge set_d or posedge clr_d or negedge reset) begin
            if (!reset) begin
                c_q <= 1'b0;
            end else if (set_d) begin
                c_q <= 1'b1;
            end else begin
                c_q <= 1'b0;
            end
        end

        // Stage register: loads on the rising edge in four-phase mode, on either edge in two-phase mode
        always_ff @(posedge c_q or negedge c_q or negedge reset) begin
            if (!reset) begin
                d_q <= '0;
            end else if (MODE || c_q) begin
                d_q <= sd[k-1];
            end
        end

        assign r[k]  = c_q;
        assign sd[k] = d_q;
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_obs
        assign stage_data[k*WIDTH-1 -: WIDTH] = sd[k];
    end

    assign ack_out   = r[1];
    assign req_out   = r[DEPTH+1];
    assign data_out  = sd[DEPTH+1];
    assign stage_req = r[DEPTH:1];

    // A stage holds a token when its request has not yet been matched by its successor
    assign tok       = r[DEPTH:1] ^ r[DEPTH+1:2];
    assign occupancy = OCC_W'($countones(tok));

endmodule
